hazard_fwd_unit: RTL and testbench

- Next-generation hazard unit for the 5-stage pipeline. Adds operand forwarding selects, load-use detection with source-use qualification, and branch flush.
- Adds a sequential per-register scoreboard for variable-latency writers, such as the multiply/divide unit.
- Sits beside the ID stage. Drives PC/IF-ID enables, the ID/EX bubble mux, and the EX forwarding muxes.

---
 rtl/hazard_fwd_unit.sv | 207 ++++++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: pipeline hazard detection and operand forwarding unit.
// Sits beside the ID stage of the 5-stage pipeline. Produces the PC / IF-ID
// enables, the IF-ID flush, the ID/EX bubble select and the two EX operand
// forwarding selects. A per-register scoreboard tracks destinations of
// variable-latency writers (multiply/divide) between issue and writeback.
// Optional build macro: HAZARD_STATS_EN adds saturating stall/flush counters
// (Stall_Cnt, Flush_Cnt) of width CNT_W.

module hazard_fwd_unit #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16,
    localparam int NUM_REGS = 2**REG_AW
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [REG_AW-1:0]   IF_ID_RS1,
    input  logic [REG_AW-1:0]   IF_ID_RS2,
    input  logic                IF_ID_Use1,
    input  logic                IF_ID_Use2,
    input  logic [REG_AW-1:0]   IF_ID_WriteReg,
    input  logic                IF_ID_RegWrite,
    input  logic                IF_ID_LongOp,

    input  logic [REG_AW-1:0]   ID_EX_RS1,
    input  logic [REG_AW-1:0]   ID_EX_RS2,
    input  logic [REG_AW-1:0]   ID_EX_WriteReg,
    input  logic                ID_EX_RegWrite,
    input  logic                ID_EX_MemRead,

    input  logic [REG_AW-1:0]   EX_MEM_WriteReg,
    input  logic                EX_MEM_RegWrite,

    input  logic [REG_AW-1:0]   MEM_WB_WriteReg,
    input  logic                MEM_WB_RegWrite,

    input  logic                LL_Issue,
    input  logic [REG_AW-1:0]   LL_IssueReg,
    input  logic                LL_Done,
    input  logic [REG_AW-1:0]   LL_DoneReg,
    input  logic                LL_Busy,

    input  logic                EX_BranchTaken,

    output logic                PC_En,
    output logic                IF_ID_En,
    output logic                IF_ID_Flush,
    output logic                Mux_sel,
    output logic [1:0]          FwdA,
    output logic [1:0]          FwdB,
    output logic [NUM_REGS-1:0] SB_Pending
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]    Stall_Cnt,
    output logic [CNT_W-1:0]    Flush_Cnt
`endif
);

    // Forwarding select encodings for the EX operand muxes.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM_WB  = 2'b01;
    localparam logic [1:0] FWD_EX_MEM  = 2'b10;

    // Register 0 is hardwired when ZERO_REG is set, so it never creates a
    // dependency of any kind.
    function automatic logic is_zero_reg(input logic [REG_AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // A source depends on a writer only if the source is really read, the
    // writer really writes, the indices agree and the register is not x0.
    function automatic logic src_hits(input logic              rd_en,
                                      input logic              wr_en,
                                      input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] dst);
        return rd_en && wr_en && (src == dst) && !is_zero_reg(src);
    endfunction

    // EX/MEM holds the younger result, so it is checked before MEM/WB.
    function automatic logic [1:0] fwd_select(input logic [REG_AW-1:0] src,
                                              input logic              exm_we,
                                              input logic [REG_AW-1:0] exm_rd,
                                              input logic              mwb_we,
                                              input logic [REG_AW-1:0] mwb_rd);
        if (src_hits(1'b1, exm_we, src, exm_rd)) begin
            return FWD_EX_MEM;
        end
        if (src_hits(1'b1, mwb_we, src, mwb_rd)) begin
            return FWD_MEM_WB;
        end
        return FWD_REGFILE;
    endfunction

    // ------------------------------------------------------------------
    // Long-latency scoreboard
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    // Next scoreboard: retire the completing register first, then mark the
    // issuing one, so a same-cycle issue and completion leaves the bit set.
    always_comb begin
        sb_d = sb_q;
        if (LL_Done) begin
            sb_d[LL_DoneReg] = 1'b0;
        end
        if (LL_Issue) begin
            sb_d[LL_IssueReg] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            sb_d[0] = 1'b0;
        end
    end

    // Scoreboard register; reset discards every outstanding entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign SB_Pending = sb_q;

    // ------------------------------------------------------------------
    // Stall detection
    // ------------------------------------------------------------------
    logic load_use;
    logic raw_pend;
    logic waw_pend;
    logic struct_haz;
    logic stall;

    // Each stall source evaluated separately so the reasons stay readable.
    always_comb begin
        load_use   = ID_EX_MemRead &&
                     (src_hits(IF_ID_Use1, ID_EX_RegWrite, IF_ID_RS1, ID_EX_WriteReg) ||
                      src_hits(IF_ID_Use2, ID_EX_RegWrite, IF_ID_RS2, ID_EX_WriteReg));
        raw_pend   = (IF_ID_Use1 && sb_q[IF_ID_RS1]) ||
                     (IF_ID_Use2 && sb_q[IF_ID_RS2]);
        waw_pend   = IF_ID_RegWrite && sb_q[IF_ID_WriteReg];
        struct_haz = IF_ID_LongOp && LL_Busy;
        stall      = load_use || raw_pend || waw_pend || struct_haz;
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------

    // A taken branch overrides any stall: the stalled instruction is on the
    // wrong path, so the front end refills while the bubble squashes ID.
    always_comb begin
        PC_En       = 1'b1;
        IF_ID_En    = 1'b1;
        IF_ID_Flush = 1'b0;
        Mux_sel     = 1'b0;
        if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            Mux_sel     = 1'b1;
        end else if (stall) begin
            PC_En    = 1'b0;
            IF_ID_En = 1'b0;
            Mux_sel  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------

    // Operand selects for the EX stage ALU inputs.
    always_comb begin
        FwdA = fwd_select(ID_EX_RS1, EX_MEM_RegWrite, EX_MEM_WriteReg,
                          MEM_WB_RegWrite, MEM_WB_WriteReg);
        FwdB = fwd_select(ID_EX_RS2, EX_MEM_RegWrite, EX_MEM_WriteReg,
                          MEM_WB_RegWrite, MEM_WB_WriteReg);
    end

`ifdef HAZARD_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters: stalls overridden by a branch count as flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !EX_BranchTaken && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (EX_BranchTaken && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed plus randomized check of hazard_fwd_unit
// against a behavioural model kept in this bench.
module tb_hazard_fwd_unit;

    localparam int AW    = 5;
    localparam int NR    = 32;
    localparam int ZR    = 1;
    localparam int CW    = 16;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] if_rs1, if_rs2, if_wr;
    logic          if_use1, if_use2, if_we, if_long;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_wr;
    logic          ex_we, ex_memrd;
    logic [AW-1:0] exm_wr, mwb_wr;
    logic          exm_we, mwb_we;
    logic          ll_issue, ll_done, ll_busy;
    logic [AW-1:0] ll_issue_reg, ll_done_reg;
    logic          br_taken;

    logic          pc_en, ifid_en, ifid_flush, mux_sel;
    logic [1:0]    fwd_a, fwd_b;
    logic [NR-1:0] sb_pending;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_AW(AW), .ZERO_REG(ZR), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_RS1(if_rs1), .IF_ID_RS2(if_rs2),
        .IF_ID_Use1(if_use1), .IF_ID_Use2(if_use2),
        .IF_ID_WriteReg(if_wr), .IF_ID_RegWrite(if_we), .IF_ID_LongOp(if_long),
        .ID_EX_RS1(ex_rs1), .ID_EX_RS2(ex_rs2), .ID_EX_WriteReg(ex_wr),
        .ID_EX_RegWrite(ex_we), .ID_EX_MemRead(ex_memrd),
        .EX_MEM_WriteReg(exm_wr), .EX_MEM_RegWrite(exm_we),
        .MEM_WB_WriteReg(mwb_wr), .MEM_WB_RegWrite(mwb_we),
        .LL_Issue(ll_issue), .LL_IssueReg(ll_issue_reg),
        .LL_Done(ll_done), .LL_DoneReg(ll_done_reg), .LL_Busy(ll_busy),
        .EX_BranchTaken(br_taken),
        .PC_En(pc_en), .IF_ID_En(ifid_en), .IF_ID_Flush(ifid_flush),
        .Mux_sel(mux_sel), .FwdA(fwd_a), .FwdB(fwd_b), .SB_Pending(sb_pending)
`ifdef HAZARD_STATS_EN
        , .Stall_Cnt(stall_cnt), .Flush_Cnt(flush_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference state: which registers await a long-latency result.
    bit pend[NR];
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;
    bit last_stall  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit isX0(int r);
        return (ZR != 0) && (r == 0);
    endfunction

    function automatic bit depends(bit rd, bit we, int src, int dst);
        return rd && we && (src == dst) && !isX0(src);
    endfunction

    // Walk writers from youngest to oldest and take the first producer.
    function automatic logic [1:0] refFwd(int src);
        int  dst[2];
        bit  wen[2];
        int  code[2];
        dst[0] = exm_wr; wen[0] = exm_we; code[0] = 2;
        dst[1] = mwb_wr; wen[1] = mwb_we; code[1] = 1;
        for (int k = 0; k < 2; k++)
            if (wen[k] && dst[k] == src && !isX0(src)) return 2'(code[k]);
        return 2'b00;
    endfunction

    task automatic clearInputs();
        {if_rs1, if_rs2, if_wr, if_use1, if_use2, if_we, if_long} = '0;
        {ex_rs1, ex_rs2, ex_wr, ex_we, ex_memrd} = '0;
        {exm_wr, mwb_wr, exm_we, mwb_we} = '0;
        {ll_issue, ll_done, ll_busy, ll_issue_reg, ll_done_reg, br_taken} = '0;
    endtask

    task automatic resetModel();
        for (int r = 0; r < NR; r++) pend[r] = 0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic checkAll(input string ctx);
        bit load_use, raw, waw, strct, stall;
        logic [3:0]  exp_ctl;
        logic [31:0] exp_sb;
        load_use = ex_memrd && (depends(if_use1, ex_we, if_rs1, ex_wr) ||
                                depends(if_use2, ex_we, if_rs2, ex_wr));
        raw   = (if_use1 && pend[if_rs1]) || (if_use2 && pend[if_rs2]);
        waw   = if_we && pend[if_wr];
        strct = if_long && ll_busy;
        stall = load_use || raw || waw || strct;
        last_stall = stall;
        if (br_taken)   exp_ctl = 4'b1111;
        else if (stall) exp_ctl = 4'b0001;
        else            exp_ctl = 4'b1100;
        for (int r = 0; r < NR; r++) exp_sb[r] = pend[r];
        checkOutput({ctx, ".ctl"}, {28'd0, pc_en, ifid_en, ifid_flush, mux_sel},
                    {28'd0, exp_ctl});
        checkOutput({ctx, ".fwdA"}, {30'd0, fwd_a}, {30'd0, refFwd(ex_rs1)});
        checkOutput({ctx, ".fwdB"}, {30'd0, fwd_b}, {30'd0, refFwd(ex_rs2)});
        checkOutput({ctx, ".sb"}, sb_pending, exp_sb);
`ifdef HAZARD_STATS_EN
        checkOutput({ctx, ".stallCnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
        checkOutput({ctx, ".flushCnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
`endif
    endtask

    // Clock-edge update of the model using the inputs held across the edge.
    task automatic stepModel();
        if (rst_n) begin
            if (ll_done)  pend[ll_done_reg]  = 0;
            if (ll_issue) pend[ll_issue_reg] = 1;
            if (ZR != 0)  pend[0] = 0;
            if (last_stall && !br_taken && m_stall_cnt < CMAX) m_stall_cnt++;
            if (br_taken && m_flush_cnt < CMAX) m_flush_cnt++;
        end
    endtask

    // Check mid-cycle, then let the clock edge happen.
    task automatic tick(input string ctx);
        #1;
        checkAll(ctx);
        @(posedge clk);
        stepModel();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] pickReg();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR - 1))
                                           : AW'($urandom_range(0, 4));
    endfunction

    task automatic applyStimulus();
        rst_n        = ($urandom_range(0, 59) != 0);
        if_rs1       = pickReg();  if_rs2 = pickReg();  if_wr = pickReg();
        if_use1      = 1'($urandom); if_use2 = 1'($urandom);
        if_we        = 1'($urandom); if_long = 1'($urandom);
        ex_rs1       = pickReg();  ex_rs2 = pickReg();  ex_wr = pickReg();
        ex_we        = 1'($urandom); ex_memrd = 1'($urandom);
        exm_wr       = pickReg();  exm_we = 1'($urandom);
        mwb_wr       = pickReg();  mwb_we = 1'($urandom);
        ll_issue     = ($urandom_range(0, 2) == 0);
        ll_issue_reg = pickReg();
        ll_done      = ($urandom_range(0, 2) == 0);
        ll_done_reg  = pickReg();
        ll_busy      = 1'($urandom);
        br_taken     = ($urandom_range(0, 7) == 0);
        if (!rst_n) resetModel();
    endtask

    initial begin
        clearInputs();
        rst_n = 1'b0;
        resetModel();
        #1;
        checkAll("reset");
        checkOutput("reset.sbZero", sb_pending, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on x5, then the consumer forwards from MEM/WB.
        ex_memrd = 1; ex_we = 1; ex_wr = 5; if_rs1 = 5; if_use1 = 1;
        #1;
        checkOutput("loadUse.ctl", {28'd0, pc_en, ifid_en, ifid_flush, mux_sel}, 32'h1);
        tick("loadUse");
        ex_memrd = 0; ex_we = 0; exm_we = 1; exm_wr = 5;
        tick("loadUse.bubble");
        exm_we = 0; mwb_we = 1; mwb_wr = 5; ex_rs1 = 5; if_use1 = 0;
        #1;
        checkOutput("loadUse.fwdA", {30'd0, fwd_a}, 32'h1);
        tick("loadUse.fwd");
        clearInputs();

        // Both later stages write x7: the younger one wins; x0 never forwards.
        exm_we = 1; exm_wr = 7; mwb_we = 1; mwb_wr = 7; ex_rs2 = 7;
        #1;
        checkOutput("fwdYoung.fwdB", {30'd0, fwd_b}, 32'h2);
        tick("fwdYoung");
        exm_wr = 0; mwb_wr = 0; ex_rs2 = 0;
        #1;
        checkOutput("fwdX0.fwdB", {30'd0, fwd_b}, 32'h0);
        tick("fwdX0");
        clearInputs();

        // Divide to x9: stall until it completes.
        ll_issue = 1; ll_issue_reg = 9;
        tick("div.issue");
        ll_issue = 0; if_rs1 = 9; if_use1 = 1;
        #1;
        checkOutput("div.sb9", {31'd0, sb_pending[9]}, 32'h1);
        checkOutput("div.stallPc", {31'd0, pc_en}, 32'h0);
        tick("div.wait1");
        tick("div.wait2");
        ll_done = 1; ll_done_reg = 9;
        tick("div.done");
        ll_done = 0;
        #1;
        checkOutput("div.sb9Clear", {31'd0, sb_pending[9]}, 32'h0);
        checkOutput("div.released", {31'd0, pc_en}, 32'h1);

        // Branch overrides an active stall.
        if_long = 1; ll_busy = 1; br_taken = 1;
        #1;
        checkOutput("branch.ctl", {28'd0, pc_en, ifid_en, ifid_flush, mux_sel}, 32'hF);
        tick("branch");
        clearInputs();

        // Same-edge issue and completion on x3 leaves it pending.
        ll_issue = 1; ll_issue_reg = 3; ll_done = 1; ll_done_reg = 3;
        tick("sameEdge");
        clearInputs();
        #1;
        checkOutput("sameEdge.sb3", {31'd0, sb_pending[3]}, 32'h1);
        #2;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("midReset.sb", sb_pending, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick("afterReset");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            applyStimulus();
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
